sda_rx: RTL and testbench

I2C slave receive front end. Samples raw SCL/SDA pins in the system clock domain, detects START/STOP, deserialises address and data bytes MSB-first, checks the 7-bit slave address, and samples the master's ACK/NACK during reads. Its outputs feed the slave controller FSM, which in turn drives the SDA output mux through its `sda_mode` selection.

---
 rtl/sda_rx_pkg.sv | 15 +
 rtl/sync_edge.sv | 25 ++
 rtl/sda_rx.sv | 132 +++++++++++++
 tb/tb_sda_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sda_rx_pkg.sv
// Shared types and widths for the I2C slave receive front end.
package sda_rx_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StData,
        StDataAck
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus one delay stage for edge detection.
// All flops reset to 1 so an idle bus produces no edge after reset.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sync,
    output logic prev
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync   <= 1'b1;
            prev   <= 1'b1;
        end else begin
            meta_q <= raw;
            sync   <= meta_q;
            prev   <= sync;
        end
    end

endmodule

// File: rtl/sda_rx.sv
// I2C slave receive front end: START/STOP detection, address check,
// write-data deserialisation and master ACK/NACK sampling during reads.
module sda_rx
    import sda_rx_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              start_found,
    output logic              stop_found,
    output logic              address_match,
    output logic              rw_mode,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              ack_valid,
    output logic              nack
);

    localparam logic [BIT_CNT_W-1:0] LastBit = BIT_CNT_W'(BYTE_W - 1);

    logic scl_s, scl_d, sda_s, sda_d;

    sync_edge u_sync_scl (
        .clk  (clk),
        .rst  (rst),
        .raw  (scl_in),
        .sync (scl_s),
        .prev (scl_d)
    );

    sync_edge u_sync_sda (
        .clk  (clk),
        .rst  (rst),
        .raw  (sda_in),
        .sync (sda_s),
        .prev (sda_d)
    );

    logic scl_rise, start_cond, stop_cond;

    assign scl_rise   = scl_s & ~scl_d;
    assign start_cond = scl_s & sda_d & ~sda_s;
    assign stop_cond  = scl_s & ~sda_d & sda_s;

    state_t                 state_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [BYTE_W-1:0]      shift_q;
    logic [BYTE_W-1:0]      shift_nxt;
    logic                   last_bit;

    assign shift_nxt = {shift_q[BYTE_W-2:0], sda_s};
    assign last_bit  = (bit_cnt_q == LastBit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            start_found   <= 1'b0;
            stop_found    <= 1'b0;
            address_match <= 1'b0;
            rw_mode       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            ack_valid     <= 1'b0;
            nack          <= 1'b0;
        end else begin
            start_found   <= 1'b0;
            stop_found    <= 1'b0;
            address_match <= 1'b0;
            rx_valid      <= 1'b0;
            ack_valid     <= 1'b0;

            if (stop_cond) begin
                state_q    <= StIdle;
                bit_cnt_q  <= '0;
                stop_found <= 1'b1;
            end else if (start_cond) begin
                state_q     <= StAddr;
                bit_cnt_q   <= '0;
                shift_q     <= '0;
                start_found <= 1'b1;
            end else if (scl_rise) begin
                case (state_q)
                    StAddr: begin
                        shift_q   <= shift_nxt;
                        // 3-bit counter wraps to 0 on the 8th bit by itself
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (last_bit) begin
                            if (shift_nxt[BYTE_W-1:1] == SLAVE_ADDR) begin
                                address_match <= 1'b1;
                                rw_mode       <= shift_nxt[0];
                                state_q       <= StAddrAck;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StAddrAck: begin
                        bit_cnt_q <= '0;
                        state_q   <= StData;
                    end
                    StData: begin
                        shift_q   <= shift_nxt;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (last_bit) begin
                            // In read mode these bits are our own transmit data
                            if (!rw_mode) begin
                                rx_data  <= shift_nxt;
                                rx_valid <= 1'b1;
                            end
                            state_q <= StDataAck;
                        end
                    end
                    StDataAck: begin
                        if (rw_mode) begin
                            ack_valid <= 1'b1;
                            nack      <= sda_s;
                        end
                        bit_cnt_q <= '0;
                        state_q   <= StData;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sda_rx.sv
// Scoreboard bench for sda_rx: directed I2C transactions push expected
// events; a monitor pops and compares on every DUT output pulse.
module tb_sda_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_in = 1'b1;
    logic       sda_in = 1'b1;
    logic       start_found, stop_found, address_match, rw_mode;
    logic [7:0] rx_data;
    logic       rx_valid, ack_valid, nack;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sda_rx #(
        .SLAVE_ADDR (7'b1111000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .scl_in        (scl_in),
        .sda_in        (sda_in),
        .start_found   (start_found),
        .stop_found    (stop_found),
        .address_match (address_match),
        .rw_mode       (rw_mode),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .ack_valid     (ack_valid),
        .nack          (nack)
    );

    typedef enum int {EvStart, EvStop, EvMatch, EvRx, EvAck} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];

    task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event got %s data=%h required no event", k.name(), d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d) begin
                n_fail++;
                $display("FAIL event got %s data=%h required %s data=%h",
                         k.name(), d, e.kind.name(), e.data);
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        n_vec++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    // Monitor: sample away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (start_found)   check_ev(EvStart, 8'h00);
            if (stop_found)    check_ev(EvStop, 8'h00);
            if (address_match) check_ev(EvMatch, {7'b0, rw_mode});
            if (rx_valid)      check_ev(EvRx, rx_data);
            if (ack_valid)     check_ev(EvAck, {7'b0, nack});
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // SCL high/low phases of 8 clk cycles: 16x oversampling
    task automatic i2c_start();
        sda_in = 1'b1; wait_clk(4);
        scl_in = 1'b1; wait_clk(8);
        sda_in = 1'b0; wait_clk(8);
        scl_in = 1'b0; wait_clk(4);
    endtask

    task automatic i2c_stop();
        sda_in = 1'b0; wait_clk(4);
        scl_in = 1'b1; wait_clk(8);
        sda_in = 1'b1; wait_clk(8);
    endtask

    task automatic send_bit(input logic b);
        sda_in = b;    wait_clk(4);
        scl_in = 1'b1; wait_clk(8);
        scl_in = 1'b0; wait_clk(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    initial begin
        // Reset with idle bus
        wait_clk(20);
        @(negedge clk);
        chk("reset_start_found", {7'b0, start_found}, 8'h00);
        chk("reset_stop_found", {7'b0, stop_found}, 8'h00);
        chk("reset_address_match", {7'b0, address_match}, 8'h00);
        chk("reset_rw_mode", {7'b0, rw_mode}, 8'h00);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_valid", {7'b0, rx_valid}, 8'h00);
        chk("reset_ack_nack", {6'b0, ack_valid, nack}, 8'h00);
        @(posedge clk);
        rst = 1'b0;
        wait_clk(10);

        // Write: address 0xF0, data 0xA5, 0x3C
        expect_ev(EvStart, 8'h00);
        expect_ev(EvMatch, 8'h00);
        expect_ev(EvRx, 8'hA5);
        expect_ev(EvRx, 8'h3C);
        expect_ev(EvStop, 8'h00);
        i2c_start();
        send_byte(8'hF0); send_bit(1'b0);
        send_byte(8'hA5); send_bit(1'b0);
        send_byte(8'h3C); send_bit(1'b0);
        i2c_stop();
        wait_clk(4);
        chk("rx_data_held", rx_data, 8'h3C);

        // Wrong address: nothing but START/STOP
        expect_ev(EvStart, 8'h00);
        expect_ev(EvStop, 8'h00);
        i2c_start();
        send_byte(8'h44); send_bit(1'b1);
        send_byte(8'hFF); send_bit(1'b1);
        i2c_stop();
        wait_clk(4);
        chk("rx_data_after_miss", rx_data, 8'h3C);

        // Read: address 0xF1, slave byte 0x5A, master NACK
        expect_ev(EvStart, 8'h00);
        expect_ev(EvMatch, 8'h01);
        expect_ev(EvAck, 8'h01);
        expect_ev(EvStop, 8'h00);
        i2c_start();
        send_byte(8'hF1); send_bit(1'b0);
        send_byte(8'h5A); send_bit(1'b1);
        i2c_stop();
        wait_clk(4);
        chk("rw_mode_read", {7'b0, rw_mode}, 8'h01);
        chk("nack_held", {7'b0, nack}, 8'h01);
        chk("rx_data_after_read", rx_data, 8'h3C);

        // STOP after 3 data bits
        expect_ev(EvStart, 8'h00);
        expect_ev(EvMatch, 8'h00);
        expect_ev(EvStop, 8'h00);
        i2c_start();
        send_byte(8'hF0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        i2c_stop();
        wait_clk(10);

        // Repeated START mid-address, then a clean write of 0x81
        expect_ev(EvStart, 8'h00);
        expect_ev(EvStart, 8'h00);
        expect_ev(EvMatch, 8'h00);
        expect_ev(EvRx, 8'h81);
        expect_ev(EvStop, 8'h00);
        i2c_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        i2c_start();
        send_byte(8'hF0); send_bit(1'b0);
        send_byte(8'h81); send_bit(1'b0);
        i2c_stop();
        wait_clk(10);
        chk("rw_mode_write", {7'b0, rw_mode}, 8'h00);
        chk("rx_data_final", rx_data, 8'h81);

        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_fail++;
            $display("FAIL missing_event got none required %s data=%h", e.kind.name(), e.data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
